// File: rtl/ast_conv_pkg.sv
// Shared types and helpers for the Avalon-ST width converters.
// Holds the narrower FSM state type, byte width and the ceil-division helper.
package ast_conv_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int unsigned words_needed(input int unsigned valid_bytes,
                                                 input int unsigned out_bytes);
        return (valid_bytes + out_bytes - 1) / out_bytes;
    endfunction

endpackage

// File: rtl/ast_word_select.sv
// Picks narrow word idx out of the registered wide beat; output is zero when not enabled.
// Latency: purely combinational.
// Backpressure: none of its own; the stable registered inputs hold the word steady.
module ast_word_select
    import ast_conv_pkg::*;
#(
    parameter int DATA_IN_W  = 64,
    parameter int DATA_OUT_W = 16,
    parameter int IDX_W      = 2
) (
    input  logic [DATA_IN_W-1:0]  beat_data,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  en,
    output logic [DATA_OUT_W-1:0] word
);

    localparam int unsigned K = DATA_IN_W / DATA_OUT_W;

    always_comb begin
        word = '0;
        if (en) begin
            for (int unsigned k = 0; k < K; k++) begin
                if (idx == IDX_W'(k)) begin
                    word = beat_data[k*DATA_OUT_W +: DATA_OUT_W];
                end
            end
        end
    end

endmodule

// File: rtl/ast_width_narrower.sv
// Avalon-ST down-converter: each wide sink beat leaves as up to K narrow words, LSB word first.
// Latency: first word is valid 1 cycle after the beat is accepted; back-to-back beats have no bubble.
// Backpressure: source outputs hold while ast_ready_i is low; ast_ready_o only rises in IDLE or on the last word.
// Optional: define AST_WIDTH_NARROWER_PKT_CNT_EN to add the pkt_cnt_o end-of-packet counter.
module ast_width_narrower
    import ast_conv_pkg::*;
#(
    parameter int DATA_IN_W   = 64,
    parameter int DATA_OUT_W  = 16,
    parameter int EMPTY_IN_W  = 3,
    parameter int EMPTY_OUT_W = 1,
    parameter int CHANNEL_W   = 10
) (
    input  logic                   clk,
    input  logic                   srst,

    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,

    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
`ifdef AST_WIDTH_NARROWER_PKT_CNT_EN
    output logic [31:0]            pkt_cnt_o,
`endif
    input  logic                   ast_ready_i
);

    localparam int unsigned IN_BYTES  = DATA_IN_W / BYTE_W;
    localparam int unsigned OUT_BYTES = DATA_OUT_W / BYTE_W;
    localparam int unsigned K         = DATA_IN_W / DATA_OUT_W;
    localparam int          IDX_W     = (K > 1) ? $clog2(K) : 1;

    // Word count and tail empty are resolved at accept time so the send path is a compare only.
    typedef struct packed {
        logic [DATA_IN_W-1:0]   data;
        logic                   sop;
        logic                   eop;
        logic [CHANNEL_W-1:0]   channel;
        logic [IDX_W-1:0]       last_idx;
        logic [EMPTY_OUT_W-1:0] last_empty;
    } beat_t;

    state_t            state, state_nxt;
    beat_t             beat;
    logic [IDX_W-1:0]  idx, idx_nxt;

    logic              send;
    logic              at_last;
    logic              accept;
    logic              src_xfer;

    int unsigned       acc_empty_in;
    int unsigned       acc_valid_bytes;
    int unsigned       acc_words;
    logic [IDX_W-1:0]       acc_last_idx;
    logic [EMPTY_OUT_W-1:0] acc_last_empty;

    assign send     = (state == SEND);
    assign at_last  = (idx == beat.last_idx);
    assign src_xfer = send & ast_ready_i;

    // Gated by srst so the sink sees not-ready while reset is held.
    assign ast_ready_o = ~srst & (~send | (at_last & ast_ready_i));
    assign accept      = ast_valid_i & ast_ready_o;

    // An oversize empty on an eop beat is clamped to one valid byte.
    always_comb begin
        acc_empty_in    = 32'(ast_empty_i);
        acc_valid_bytes = IN_BYTES;
        acc_words       = K;
        if (ast_endofpacket_i) begin
            acc_valid_bytes = (acc_empty_in >= IN_BYTES) ? 32'd1 : (IN_BYTES - acc_empty_in);
            acc_words       = words_needed(acc_valid_bytes, OUT_BYTES);
        end
        acc_last_idx   = IDX_W'(acc_words - 1);
        acc_last_empty = EMPTY_OUT_W'(acc_words * OUT_BYTES - acc_valid_bytes);
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (src_xfer) begin
            if (at_last) begin
                state_nxt = IDLE;
            end else begin
                idx_nxt = idx + IDX_W'(1);
            end
        end
        if (accept) begin
            state_nxt = SEND;
            idx_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state <= IDLE;
            idx   <= '0;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                beat.data       <= ast_data_i;
                beat.sop        <= ast_startofpacket_i;
                beat.eop        <= ast_endofpacket_i;
                beat.channel    <= ast_channel_i;
                beat.last_idx   <= ast_endofpacket_i ? acc_last_idx : IDX_W'(K - 1);
                beat.last_empty <= ast_endofpacket_i ? acc_last_empty : '0;
            end
        end
    end

    ast_word_select #(
        .DATA_IN_W  (DATA_IN_W),
        .DATA_OUT_W (DATA_OUT_W),
        .IDX_W      (IDX_W)
    ) u_word_select (
        .beat_data (beat.data),
        .idx       (idx),
        .en        (send),
        .word      (ast_data_o)
    );

    assign ast_valid_o         = send;
    assign ast_startofpacket_o = send & beat.sop & (idx == '0);
    assign ast_endofpacket_o   = send & beat.eop & at_last;
    assign ast_empty_o         = ast_endofpacket_o ? beat.last_empty : '0;
    assign ast_channel_o       = send ? beat.channel : '0;

`ifdef AST_WIDTH_NARROWER_PKT_CNT_EN
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            pkt_cnt_o <= '0;
        end else if (src_xfer && ast_endofpacket_o) begin
            pkt_cnt_o <= pkt_cnt_o + 32'd1;
        end
    end
`endif

endmodule
